// File: rtl/sample_frame_buffer_if.sv
// sample_frame_buffer_if: sample stream in, FFT frame handoff out
interface sample_frame_buffer_if #(parameter int WIDTH = 12, parameter int N = 64);
  logic sample_valid;
  logic [WIDTH-1:0] sample_in;
  logic fft_start;
  logic fft_done;
  logic [WIDTH-1:0] time_samples [0:N-1];
  logic fft_busy;
  logic [15:0] frame_cnt;
  logic overrun;
  modport master (output sample_valid, sample_in, fft_done, input fft_start, time_samples, fft_busy, frame_cnt, overrun);
  modport slave (input sample_valid, sample_in, fft_done, output fft_start, time_samples, fft_busy, frame_cnt, overrun);
endinterface

// File: rtl/sample_frame_buffer.sv
// sample_frame_buffer: ping-pong N-sample frame buffer feeding the FFT; HANN_WINDOW_EN adds a registered Hann window stage (N<=64)
module sample_frame_buffer #(
  parameter int WIDTH = 12,
  parameter int N = 64
) (
  input logic clk,
  input logic rst,
  sample_frame_buffer_if.slave bus
);
  localparam int IW = $clog2(N);
  typedef enum logic {FILL, FULL_WAIT} state_t;
  state_t state, state_n;
  logic wr_sel;
  logic [IW-1:0] wr_idx;
  logic [WIDTH-1:0] bank0 [N];
  logic [WIDTH-1:0] bank1 [N];
  logic wv;
  logic [WIDTH-1:0] wd;
  logic swap_ok, swap, wr_en, drop, last;
`ifdef HANN_WINDOW_EN
  localparam logic [10:0] HANN [0:32] = '{
    11'd0, 11'd5, 11'd20, 11'd44, 11'd78, 11'd121, 11'd172, 11'd232,
    11'd300, 11'd374, 11'd455, 11'd541, 11'd632, 11'd726, 11'd824, 11'd923,
    11'd1024, 11'd1124, 11'd1223, 11'd1321, 11'd1415, 11'd1506, 11'd1592, 11'd1673,
    11'd1747, 11'd1815, 11'd1875, 11'd1926, 11'd1969, 11'd2003, 11'd2027, 11'd2042,
    11'd2047};
  logic v_q;
  logic [WIDTH-1:0] s_q;
  logic [IW:0] fold;
  logic [6:0] ri;
  logic [WIDTH+11:0] prod;
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= 1'b0;
      s_q <= '0;
    end else begin
      v_q <= bus.sample_valid;
      s_q <= bus.sample_in;
    end
  end
  always_comb begin
    fold = ({1'b0, wr_idx} > (IW+1)'(N/2)) ? (IW+1)'(N) - {1'b0, wr_idx} : {1'b0, wr_idx};
    ri = 7'(fold * (IW+1)'(64/N));
    prod = {{12{s_q[WIDTH-1]}}, s_q} * {{(WIDTH+1){1'b0}}, HANN[ri]};
  end
  assign wv = v_q;
  assign wd = WIDTH'(prod >> 11);
`else
  assign wv = bus.sample_valid;
  assign wd = bus.sample_in;
`endif
  assign swap_ok = !bus.fft_busy || bus.fft_done;
  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else state <= state_n;
  end
  always_comb begin
    state_n = swap ? FILL : (last ? FULL_WAIT : state);
  end
  always_comb begin
    wr_en = wv && state == FILL;
    drop = wv && state == FULL_WAIT;
    last = wr_en && wr_idx == IW'(N-1);
    swap = swap_ok && (state == FULL_WAIT || last);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_sel <= 1'b0;
      wr_idx <= '0;
      bus.fft_start <= 1'b0;
      bus.fft_busy <= 1'b0;
      bus.frame_cnt <= '0;
      bus.overrun <= 1'b0;
      for (int k = 0; k < N; k++) begin
        bank0[k] <= '0;
        bank1[k] <= '0;
      end
    end else begin
      if (wr_en && !wr_sel) bank0[wr_idx] <= wd;
      if (wr_en && wr_sel) bank1[wr_idx] <= wd;
      wr_idx <= swap ? '0 : wr_idx + IW'(wr_en);
      wr_sel <= wr_sel ^ swap;
      bus.fft_start <= swap;
      bus.fft_busy <= swap || (bus.fft_busy && !bus.fft_done);
      bus.frame_cnt <= bus.frame_cnt + 16'(swap);
      bus.overrun <= bus.overrun || drop;
    end
  end
  for (genvar k = 0; k < N; k++) begin : g_rd
    assign bus.time_samples[k] = wr_sel ? bank0[k] : bank1[k];
  end
endmodule
